// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants, FSM state type, packed time type and
// time helpers for the RTC timekeeper.
package rtc_pkg;

  localparam logic [5:0] MAX_HOURS   = 6'd23;
  localparam logic [5:0] MAX_MINUTES = 6'd59;
  localparam logic [5:0] MAX_SECONDS = 6'd59;

  typedef enum logic {RUN = 1'b0, CHECK = 1'b1} rtc_state_e;

  typedef struct packed {
    logic [5:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } rtc_time_t;

  // One-second advance with carries; 23:59:59 wraps to 00:00:00.
  function automatic rtc_time_t time_inc(input rtc_time_t t);
    rtc_time_t n;
    n = t;
    if (t.seconds != MAX_SECONDS) begin
      n.seconds = t.seconds + 6'd1;
    end else begin
      n.seconds = '0;
      if (t.minutes != MAX_MINUTES) begin
        n.minutes = t.minutes + 6'd1;
      end else begin
        n.minutes = '0;
        n.hours   = (t.hours == MAX_HOURS) ? '0 : t.hours + 6'd1;
      end
    end
    return n;
  endfunction

  function automatic logic time_ok(input rtc_time_t t);
    return (t.hours <= MAX_HOURS) && (t.minutes <= MAX_MINUTES) &&
           (t.seconds <= MAX_SECONDS);
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: counts 0..TICK_DIV-1 while en=1, tick on terminal count.
// Ports: clk, rst_n (async low), en (count enable, holds when low),
//        clr (sync clear to 0, wins over en), tick (combinational strobe).
module rtc_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == TERM);

endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: hh:mm:ss real-time clock with validated time load.
// Ports: clk, rst_n (async low); en (count enable);
//        set_valid/set_ready + set_hours/minutes/seconds (load handshake);
//        rtc_hours/minutes/seconds (current time, registered);
//        sec_pulse, day_pulse, set_error (one-cycle registered strobes).
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [5:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  output logic [5:0] rtc_hours,
  output logic [5:0] rtc_minutes,
  output logic [5:0] rtc_seconds,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       set_error
);

  rtc_state_e r_state, w_state_nxt;
  rtc_time_t  r_time, r_hold;
  logic       r_set_ready, r_sec_pulse, r_day_pulse, r_set_error;
  logic       w_tick, w_accept, w_load_ok, w_load_bad, w_rollover;

  // A valid load restarts the second, so the prescaler is cleared with it.
  rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (w_load_ok),
    .tick (w_tick)
  );

  assign w_rollover = (r_time.hours == MAX_HOURS) && (r_time.minutes == MAX_MINUTES) &&
                      (r_time.seconds == MAX_SECONDS);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_ok   = 1'b0;
    w_load_bad  = 1'b0;
    case (r_state)
      RUN: begin
        if (set_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_state_nxt = RUN;
        if (time_ok(r_hold)) w_load_ok  = 1'b1;
        else                 w_load_bad = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_set_ready <= 1'b1;
      r_time      <= '0;
      r_hold      <= '0;
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
      r_set_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_set_ready <= (w_state_nxt == RUN);
      r_set_error <= w_load_bad;
      r_sec_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
      if (w_accept) r_hold <= {set_hours, set_minutes, set_seconds};
      // Valid load beats a coincident tick; a rejected load lets it through.
      if (w_load_ok) begin
        r_time <= r_hold;
      end else if (w_tick) begin
        r_time      <= time_inc(r_time);
        r_sec_pulse <= 1'b1;
        r_day_pulse <= w_rollover;
      end
    end
  end

  assign set_ready   = r_set_ready;
  assign rtc_hours   = r_time.hours;
  assign rtc_minutes = r_time.minutes;
  assign rtc_seconds = r_time.seconds;
  assign sec_pulse   = r_sec_pulse;
  assign day_pulse   = r_day_pulse;
  assign set_error   = r_set_error;

endmodule

// File: tb/tb_rtc_timekeeper.sv
module tb_rtc_timekeeper;
  localparam int TD = 4;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, set_valid = 1'b0;
  logic [5:0] set_hours = '0, set_minutes = '0, set_seconds = '0;
  logic       set_ready, sec_pulse, day_pulse, set_error;
  logic [5:0] rtc_hours, rtc_minutes, rtc_seconds;

  int n_vec = 0, n_err = 0;

  rtc_timekeeper #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .set_valid(set_valid), .set_ready(set_ready),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
    .rtc_hours(rtc_hours), .rtc_minutes(rtc_minutes), .rtc_seconds(rtc_seconds),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse), .set_error(set_error)
  );

  always #5 clk = ~clk;

  // Reference model: time kept as seconds-of-day, prescaler as an integer.
  int   m_sod, m_pre, m_hh, m_mm, m_ss;
  logic m_pend, m_ready, m_sec, m_day, m_err;
  logic m_tick, m_hold_ok;
  assign m_tick    = en && (m_pre == TD - 1);
  assign m_hold_ok = (m_hh < 24) && (m_mm < 60) && (m_ss < 60);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sod <= 0; m_pre <= 0; m_pend <= 1'b0; m_ready <= 1'b1;
      m_sec <= 1'b0; m_day <= 1'b0; m_err <= 1'b0;
      m_hh <= 0; m_mm <= 0; m_ss <= 0;
    end else begin
      m_sec <= 1'b0; m_day <= 1'b0; m_err <= 1'b0;
      if (en) m_pre <= (m_pre + 1) % TD;
      if (m_pend && m_hold_ok) begin
        m_pend <= 1'b0; m_ready <= 1'b1;
        m_sod  <= m_hh * 3600 + m_mm * 60 + m_ss;
        m_pre  <= 0;
      end else begin
        if (m_pend) begin
          m_pend <= 1'b0; m_ready <= 1'b1; m_err <= 1'b1;
        end else if (set_valid) begin
          m_pend <= 1'b1; m_ready <= 1'b0;
          m_hh <= int'(set_hours); m_mm <= int'(set_minutes); m_ss <= int'(set_seconds);
        end
        if (m_tick) begin
          m_sod <= (m_sod + 1) % 86400;
          m_sec <= 1'b1;
          m_day <= (m_sod == 86399);
        end
      end
    end
  end

  function automatic logic [21:0] model_vec();
    return {6'(m_sod / 3600), 6'((m_sod / 60) % 60), 6'(m_sod % 60),
            m_sec, m_day, m_err, m_ready};
  endfunction

  logic [21:0] dut_vec;
  assign dut_vec = {rtc_hours, rtc_minutes, rtc_seconds, sec_pulse, day_pulse, set_error, set_ready};

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic load(input int h, input int m, input int s);
    set_valid = 1'b1;
    set_hours = 6'(h); set_minutes = 6'(m); set_seconds = 6'(s);
    cyc(1);
    set_valid = 1'b0;
    set_hours = 6'($urandom); set_minutes = 6'($urandom); set_seconds = 6'($urandom);
    cyc(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    cyc(2);
    n_vec++;
    if (dut_vec !== 22'h1) begin
      n_err++; $display("FAIL reset_state got %h exp %h", dut_vec, 22'h1);
    end
    n_vec++;
    if (dut_vec !== model_vec()) begin
      n_err++; $display("FAIL reset_model got %h exp %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_count();
    rst_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      n_vec++;
      if (sec_pulse !== ((k % 4) == 0)) begin
        n_err++; $display("FAIL count_pulse cyc=%0d got %b exp %b", k, sec_pulse, (k % 4) == 0);
      end
    end
    n_vec++;
    if (dut_vec !== {6'd0, 6'd0, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL count_time got %h exp sec=3 pulse=1", dut_vec);
    end
  endtask

  task automatic test_rollover();
    en = 1'b1;
    load(23, 59, 58);
    n_vec++;
    if ({rtc_hours, rtc_minutes, rtc_seconds, sec_pulse} !== {6'd23, 6'd59, 6'd58, 1'b0}) begin
      n_err++; $display("FAIL roll_load got %0d:%0d:%0d p=%b exp 23:59:58 p=0",
                        rtc_hours, rtc_minutes, rtc_seconds, sec_pulse);
    end
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      n_vec++;
      if (day_pulse !== (k == 8)) begin
        n_err++; $display("FAIL roll_daypulse cyc=%0d got %b exp %b", k, day_pulse, k == 8);
      end
      if (k == 4) begin
        n_vec++;
        if ({rtc_hours, rtc_minutes, rtc_seconds} !== {6'd23, 6'd59, 6'd59}) begin
          n_err++; $display("FAIL roll_5959 got %0d:%0d:%0d exp 23:59:59", rtc_hours, rtc_minutes, rtc_seconds);
        end
      end
    end
    n_vec++;
    if ({rtc_hours, rtc_minutes, rtc_seconds, sec_pulse} !== {18'd0, 1'b1}) begin
      n_err++; $display("FAIL roll_midnight got %0d:%0d:%0d p=%b exp 0:0:0 p=1",
                        rtc_hours, rtc_minutes, rtc_seconds, sec_pulse);
    end
  endtask

  task automatic test_invalid();
    logic [17:0] bad [4];
    logic [21:0] exp_v;
    bad[0] = {6'd24, 6'd0, 6'd0};  bad[1] = {6'd12, 6'd60, 6'd0};
    bad[2] = {6'd12, 6'd0, 6'd60}; bad[3] = {6'd63, 6'd63, 6'd63};
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_valid = 1'b1;
      {set_hours, set_minutes, set_seconds} = bad[i];
      cyc(1);
      set_valid = 1'b0;
      n_vec++;
      if ({set_ready, set_error} !== 2'b00) begin
        n_err++; $display("FAIL inv_check[%0d] ready/err got %b exp 00", i, {set_ready, set_error});
      end
      cyc(1);
      exp_v = {6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      n_vec++;
      if (dut_vec !== exp_v) begin
        n_err++; $display("FAIL inv_reject[%0d] got %h exp %h", i, dut_vec, exp_v);
      end
      cyc(1);
      n_vec++;
      if ({set_ready, set_error} !== 2'b10) begin
        n_err++; $display("FAIL inv_after[%0d] ready/err got %b exp 10", i, {set_ready, set_error});
      end
    end
  endtask

  task automatic test_collision();
    int guard = 0;
    en = 1'b1;
    while (m_pre != 2 && guard < 10) begin cyc(1); guard++; end
    n_vec++;
    if (guard >= 10) begin
      n_err++; $display("FAIL coll_align got timeout exp prescaler phase 2");
    end
    load(10, 20, 30);
    n_vec++;
    if ({rtc_hours, rtc_minutes, rtc_seconds, sec_pulse} !== {6'd10, 6'd20, 6'd30, 1'b0}) begin
      n_err++; $display("FAIL coll_load got %0d:%0d:%0d p=%b exp 10:20:30 p=0",
                        rtc_hours, rtc_minutes, rtc_seconds, sec_pulse);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      n_vec++;
      if (sec_pulse !== (k == 4)) begin
        n_err++; $display("FAIL coll_pulse cyc=%0d got %b exp %b", k, sec_pulse, k == 4);
      end
    end
    n_vec++;
    if (rtc_seconds !== 6'd31) begin
      n_err++; $display("FAIL coll_next got %0d exp 31", rtc_seconds);
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1;
    cyc(2);
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      n_vec++;
      if ({rtc_seconds, sec_pulse} !== {6'd31, 1'b0}) begin
        n_err++; $display("FAIL hold_frozen cyc=%0d got s=%0d p=%b exp s=31 p=0", k, rtc_seconds, sec_pulse);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      cyc(1);
      n_vec++;
      if (sec_pulse !== (k == 2)) begin
        n_err++; $display("FAIL hold_resume cyc=%0d got %b exp %b", k, sec_pulse, k == 2);
      end
    end
    n_vec++;
    if (rtc_seconds !== 6'd32) begin
      n_err++; $display("FAIL hold_sec got %0d exp 32", rtc_seconds);
    end
  endtask

  task automatic test_load_en_low();
    en = 1'b0;
    load(5, 6, 7);
    cyc(6);
    n_vec++;
    if ({rtc_hours, rtc_minutes, rtc_seconds, sec_pulse} !== {6'd5, 6'd6, 6'd7, 1'b0}) begin
      n_err++; $display("FAIL enlow_load got %0d:%0d:%0d p=%b exp 5:6:7 p=0",
                        rtc_hours, rtc_minutes, rtc_seconds, sec_pulse);
    end
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      n_vec++;
      if (sec_pulse !== (k == 4)) begin
        n_err++; $display("FAIL enlow_pulse cyc=%0d got %b exp %b", k, sec_pulse, k == 4);
      end
    end
  endtask

  task automatic test_reset_check();
    en = 1'b1;
    set_valid = 1'b1;
    set_hours = 6'd1; set_minutes = 6'd2; set_seconds = 6'd3;
    cyc(1);
    set_valid = 1'b0;
    n_vec++;
    if (set_ready !== 1'b0) begin
      n_err++; $display("FAIL rstchk_incheck got ready=%b exp 0", set_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (dut_vec !== 22'h1) begin
      n_err++; $display("FAIL rstchk_async got %h exp %h", dut_vec, 22'h1);
    end
    @(negedge clk);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    n_vec++;
    if (dut_vec !== 22'h1) begin
      n_err++; $display("FAIL rstchk_release got %h exp %h", dut_vec, 22'h1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 9) != 0);
      set_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: begin set_hours = 6'd23; set_minutes = 6'd59; set_seconds = 6'($urandom_range(50, 59)); end
        1: begin set_hours = 6'($urandom); set_minutes = 6'($urandom); set_seconds = 6'($urandom); end
        default: begin
          set_hours = 6'($urandom_range(0, 23)); set_minutes = 6'($urandom_range(0, 59));
          set_seconds = 6'($urandom_range(0, 59));
        end
      endcase
      cyc(1);
      n_vec++;
      if (dut_vec !== model_vec()) begin
        n_err++; $display("FAIL rand cyc=%0d got %h exp %h", c, dut_vec, model_vec());
      end
      if (rtc_hours > 6'd23 || rtc_minutes > 6'd59 || rtc_seconds > 6'd59) begin
        n_err++; $display("FAIL rand_range cyc=%0d got %0d:%0d:%0d exp in range",
                          c, rtc_hours, rtc_minutes, rtc_seconds);
      end
    end
    set_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_invalid();
    test_collision();
    test_enable_hold();
    test_load_en_low();
    test_reset_check();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
